id_ex_stage: RTL and testbench

//  ID/EX pipeline register for the 5-stage 32-bit MIPS core, with load-use hazard detection and forwarding-select generation.

---
 rtl/id_ex_stage.sv | 180 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and forwarding
// selects. IDEX_FORWARD_EN enables forwarding; otherwise RAW hazards stall.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   id_*                        decoded ID-stage instruction fields
//   flush                       kill the ID instruction (taken branch/jump)
//   exmem_reg_write/exmem_rd    EX/MEM destination info
//   memwb_reg_write/memwb_rd    MEM/WB destination info
//   ex_*                        registered EX-stage copies
//   stall                       hold PC and IF/ID (combinational)
//   fwd_a/fwd_b                 ALU operand mux selects (combinational)
//   stall_cnt                   saturating count of stall cycles
module id_ex_stage #(
   parameter int unsigned DW     = 32,
   parameter int unsigned AW     = 5,
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [DW-1:0]     id_pc4,
   input  logic [DW-1:0]     id_rs_data,
   input  logic [DW-1:0]     id_rt_data,
   input  logic [DW-1:0]     id_imm,
   input  logic [AW-1:0]     id_rs,
   input  logic [AW-1:0]     id_rt,
   input  logic [AW-1:0]     id_rd,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   input  logic              exmem_reg_write,
   input  logic [AW-1:0]     exmem_rd,
   input  logic              memwb_reg_write,
   input  logic [AW-1:0]     memwb_rd,
   output logic              ex_valid,
   output logic [DW-1:0]     ex_pc4,
   output logic [DW-1:0]     ex_rs_data,
   output logic [DW-1:0]     ex_rt_data,
   output logic [DW-1:0]     ex_imm,
   output logic [AW-1:0]     ex_rs,
   output logic [AW-1:0]     ex_rt,
   output logic [AW-1:0]     ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              stall,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              valid_q, valid_d;
   logic [DW-1:0]     pc4_q, pc4_d;
   logic [DW-1:0]     rs_data_q, rs_data_d;
   logic [DW-1:0]     rt_data_q, rt_data_d;
   logic [DW-1:0]     imm_q, imm_d;
   logic [AW-1:0]     rs_q, rs_d;
   logic [AW-1:0]     rt_q, rt_d;
   logic [AW-1:0]     rd_q, rd_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              reg_write_q, reg_write_d;
   logic              mem_read_q, mem_read_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic load_use;
   logic hz;
   logic bubble;

   always_comb begin
      load_use = id_valid & valid_q & mem_read_q & (rt_q != '0) &
                 ((rt_q == id_rs) | (rt_q == id_rt));
`ifdef IDEX_FORWARD_EN
      hz = load_use;
`else
      // Without forwarding, any pending write from EX or EX/MEM must
      // retire before ID may read; MEM/WB is covered by the regfile.
      hz = load_use |
           (id_valid & valid_q & reg_write_q & (rd_q != '0) &
            ((rd_q == id_rs) | (rd_q == id_rt))) |
           (id_valid & exmem_reg_write & (exmem_rd != '0) &
            ((exmem_rd == id_rs) | (exmem_rd == id_rt)));
`endif
      // A taken redirect kills ID anyway, so it never needs holding.
      stall  = hz & ~flush;
      bubble = flush | hz;
   end

`ifdef IDEX_FORWARD_EN
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (valid_q) begin
         if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q)
            fwd_a = 2'b01;
         else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q)
            fwd_a = 2'b10;
         if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q)
            fwd_b = 2'b01;
         else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q)
            fwd_b = 2'b10;
      end
   end
`else
   logic unused_memwb;
   assign unused_memwb = memwb_reg_write ^ (^memwb_rd);
   assign fwd_a = 2'b00;
   assign fwd_b = 2'b00;
`endif

   always_comb begin
      valid_d     = id_valid;
      pc4_d       = id_pc4;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = id_imm;
      rs_d        = id_rs;
      rt_d        = id_rt;
      rd_d        = id_rd;
      ctrl_d      = id_ctrl;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      // Bubble kills only the side-effect fields; data is don't-care.
      if (bubble) begin
         valid_d     = 1'b0;
         ctrl_d      = '0;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
      end
      cnt_d = cnt_q;
      if (stall && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         pc4_q       <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         ctrl_q      <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         valid_q     <= valid_d;
         pc4_q       <= pc4_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_q       <= imm_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         ctrl_q      <= ctrl_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ex_valid     = valid_q;
   assign ex_pc4       = pc4_q;
   assign ex_rs_data   = rs_data_q;
   assign ex_rt_data   = rt_data_q;
   assign ex_imm       = imm_q;
   assign ex_rs        = rs_q;
   assign ex_rt        = rt_q;
   assign ex_rd        = rd_q;
   assign ex_ctrl      = ctrl_q;
   assign ex_reg_write = reg_write_q;
   assign ex_mem_read  = mem_read_q;
   assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of expected EX records,
// hazard/stall expectations and a saturating stall counter model.
module tb_id_ex_stage;

`ifdef IDEX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [7:0]  id_ctrl;
   logic        id_reg_write, id_mem_read, flush;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        ex_valid, ex_reg_write, ex_mem_read, stall;
   logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [7:0]  ex_ctrl;
   logic [1:0]  fwd_a, fwd_b;
   logic [3:0]  stall_cnt;

   id_ex_stage #(.DW(32), .AW(5), .CTRL_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc4(id_pc4),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .flush(flush), .exmem_reg_write(exmem_reg_write),
      .exmem_rd(exmem_rd), .memwb_reg_write(memwb_reg_write),
      .memwb_rd(memwb_rd), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v, rw, mr, bub;
      logic [31:0] pc4, rsd, rtd, imm;
      logic [4:0]  rs, rt, rd;
      logic [7:0]  ctrl;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [7:0] c,
                         input logic rw, input logic mr);
      id_valid     = v;
      id_pc4       = pc;
      id_rs_data   = pc ^ 32'hA5A5_0000;
      id_rt_data   = pc ^ 32'h0000_5A5A;
      id_imm       = ~pc;
      id_rs        = rs;
      id_rt        = rt;
      id_rd        = rd;
      id_ctrl      = c;
      id_reg_write = rw;
      id_mem_read  = mr;
   endtask

   // One clocked step: check stall, push expected EX record, clock, compare.
   task automatic step(input string tag, input logic xs, input logic xb);
      exp_t e;
      #1;
      chk({tag, "_stall"}, stall, xs);
      e.bub  = xb;
      e.v    = xb ? 1'b0 : id_valid;
      e.rw   = xb ? 1'b0 : id_reg_write;
      e.mr   = xb ? 1'b0 : id_mem_read;
      e.ctrl = xb ? 8'h00 : id_ctrl;
      e.pc4  = id_pc4;
      e.rsd  = id_rs_data;
      e.rtd  = id_rt_data;
      e.imm  = id_imm;
      e.rs   = id_rs;
      e.rt   = id_rt;
      e.rd   = id_rd;
      if (xs && exp_cnt != 15) exp_cnt++;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      chk({tag, "_sbq"}, sbq.size(), 1);
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         chk({tag, "_valid"}, ex_valid, e.v);
         chk({tag, "_rw"}, ex_reg_write, e.rw);
         chk({tag, "_mr"}, ex_mem_read, e.mr);
         chk({tag, "_ctrl"}, ex_ctrl, e.ctrl);
         if (!e.bub) begin
            chk({tag, "_pc4"}, ex_pc4, e.pc4);
            chk({tag, "_rsd"}, ex_rs_data, e.rsd);
            chk({tag, "_rtd"}, ex_rt_data, e.rtd);
            chk({tag, "_imm"}, ex_imm, e.imm);
            chk({tag, "_idx"}, {ex_rs, ex_rt, ex_rd}, {e.rs, e.rt, e.rd});
         end
      end
      chk({tag, "_cnt"}, stall_cnt, exp_cnt);
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      exmem_reg_write = 1'b0;
      exmem_rd = 5'd0;
      memwb_reg_write = 1'b0;
      memwb_rd = 5'd0;
      set_id(1, 32'h1234, 8, 8, 8, 8'hFF, 1, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", ex_valid, 0);
      chk("rst_pc4", ex_pc4, 0);
      chk("rst_ctrl", ex_ctrl, 0);
      chk("rst_rwmr", {ex_reg_write, ex_mem_read}, 0);
      chk("rst_idx", {ex_rs, ex_rt, ex_rd}, 0);
      chk("rst_stall", stall, 0);
      chk("rst_fwd", {fwd_a, fwd_b}, 0);
      chk("rst_cnt", stall_cnt, 0);
      rst_n = 1'b1;

      // Load-use: lw $8 then add using $8.
      set_id(1, 32'h100, 1, 8, 8, 8'h11, 1, 1);
      step("lw", 0, 0);
      set_id(1, 32'h104, 8, 9, 10, 8'h22, 1, 0);
      step("lu_stall", 1, 1);
      step("lu_issue", 0, 0);
      chk("lu_cnt1", stall_cnt, 1);

      // Forwarding priority on EX instruction rs=5 rt=6.
      set_id(1, 32'h108, 5, 6, 7, 8'h33, 1, 0);
      step("fw_src", 0, 0);
      id_valid = 1'b0;
      exmem_reg_write = 1'b1;
      exmem_rd = 5'd5;
      memwb_reg_write = 1'b1;
      memwb_rd = 5'd5;
      #1;
      chk("fwd_both_a", fwd_a, FWD ? 2'b01 : 2'b00);
      chk("fwd_both_b", fwd_b, 2'b00);
      exmem_reg_write = 1'b0;
      #1;
      chk("fwd_memwb_a", fwd_a, FWD ? 2'b10 : 2'b00);
      memwb_rd = 5'd6;
      #1;
      chk("fwd_b_a", fwd_a, 2'b00);
      chk("fwd_b_b", fwd_b, FWD ? 2'b10 : 2'b00);
      memwb_reg_write = 1'b0;

      // ID reads a register EX/MEM is writing.
      exmem_reg_write = 1'b1;
      exmem_rd = 5'd5;
      set_id(1, 32'h10C, 5, 0, 11, 8'h44, 1, 0);
      #1;
      chk("exmem_fwd_a", fwd_a, FWD ? 2'b01 : 2'b00);
      step("exmem_dep", !FWD, !FWD);
      exmem_reg_write = 1'b0;

      // ID reads the EX destination of a non-load.
      set_id(1, 32'h110, 12, 13, 14, 8'h55, 1, 0);
      step("ex_src", 0, 0);
      set_id(1, 32'h114, 0, 14, 15, 8'h66, 1, 0);
      step("ex_dep", !FWD, !FWD);

      // $0 is never forwarded nor a hazard.
      set_id(1, 32'h118, 0, 0, 0, 8'h77, 1, 1);
      step("lw_r0", 0, 0);
      exmem_reg_write = 1'b1;
      exmem_rd = 5'd0;
      set_id(1, 32'h11C, 0, 0, 4, 8'h88, 1, 0);
      #1;
      chk("r0_fwd", {fwd_a, fwd_b}, 0);
      step("r0_use", 0, 0);
      exmem_reg_write = 1'b0;

      // Flush wins over a load-use hazard.
      set_id(1, 32'h120, 2, 8, 8, 8'h99, 1, 1);
      step("fl_lw", 0, 0);
      set_id(1, 32'h124, 8, 3, 9, 8'hAA, 1, 0);
      flush = 1'b1;
      step("flush_hz", 0, 1);
      flush = 1'b0;

      // Counter saturation.
      for (int i = 0; i < 20; i++) begin
         set_id(1, 32'h200 + 8 * i, 1, 8, 8, 8'hC0, 1, 1);
         step("sat_lw", 0, 0);
         set_id(1, 32'h204 + 8 * i, 8, 9, 10, 8'hC1, 1, 0);
         step("sat_st", 1, 1);
      end
      chk("sat_cnt", stall_cnt, 15);

      // Reset in the middle of a stall.
      set_id(1, 32'h300, 1, 8, 8, 8'hD0, 1, 1);
      step("mr_lw", 0, 0);
      set_id(1, 32'h304, 8, 9, 10, 8'hD1, 1, 0);
      #1;
      chk("mr_pre", stall, 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mr_valid", ex_valid, 0);
      chk("mr_mr", ex_mem_read, 0);
      chk("mr_ctrl", ex_ctrl, 0);
      chk("mr_pc4", ex_pc4, 0);
      chk("mr_cnt", stall_cnt, 0);
      chk("mr_stall", stall, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
